// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detection, PAUSED/RUNNING/ADJUST control,
// 1 Hz and adjust prescalers, and MM:SS time kept as four registered BCD digits.
module stopwatch_ctrl #(
    parameter int unsigned SEC_DIV = 100000000,
    parameter int unsigned ADJ_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause_state,
    input  logic       reset_state,
    input  logic       adj_state,
    input  logic       sel_state,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       adjusting,
    output logic       blink
);

    localparam int unsigned SW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
    localparam int unsigned AW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam logic [SW-1:0] SEC_LAST = SW'(SEC_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST = AW'(ADJ_DIV - 1);

    typedef enum logic [1:0] {
        PAUSED,
        RUNNING,
        ADJUST
    } state_t;

    state_t        state;
    logic [SW-1:0] sec_presc;
    logic [AW-1:0] adj_presc;
    logic          pause_q;
    logic          reset_q;
    logic          pause_press;
    logic          reset_press;

    assign pause_press = pause_state & ~pause_q;
    assign reset_press = reset_state & ~reset_q;

    // Two-digit BCD increment modulo 60 ({tens, ones}).
    function automatic logic [7:0] inc60(input logic [7:0] bcd);
        logic [7:0] r;
        if (bcd[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (bcd[7:4] == 4'd5) ? 4'd0 : bcd[7:4] + 4'd1;
        end else begin
            r[3:0] = bcd[3:0] + 4'd1;
            r[7:4] = bcd[7:4];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PAUSED;
            sec_presc <= '0;
            adj_presc <= '0;
            pause_q   <= 1'b0;
            reset_q   <= 1'b0;
            min_tens  <= '0;
            min_ones  <= '0;
            sec_tens  <= '0;
            sec_ones  <= '0;
            running   <= 1'b0;
            adjusting <= 1'b0;
            blink     <= 1'b0;
        end else begin
            pause_q <= pause_state;
            reset_q <= reset_state;

            if (reset_press) begin
                // Clear wins over everything, including a coincident pause press
                // and a sec tick that would otherwise fire on this edge.
                min_tens  <= '0;
                min_ones  <= '0;
                sec_tens  <= '0;
                sec_ones  <= '0;
                sec_presc <= '0;
                adj_presc <= '0;
                blink     <= 1'b0;
                state     <= adj_state ? ADJUST : PAUSED;
                running   <= 1'b0;
                adjusting <= adj_state;
            end else if (adj_state && state != ADJUST) begin
                state     <= ADJUST;
                adj_presc <= '0;
                blink     <= 1'b0;
                running   <= 1'b0;
                adjusting <= 1'b1;
            end else if (!adj_state && state == ADJUST) begin
                state     <= PAUSED;
                blink     <= 1'b0;
                running   <= 1'b0;
                adjusting <= 1'b0;
            end else begin
                case (state)
                    PAUSED: begin
                        if (pause_press) begin
                            state   <= RUNNING;
                            running <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        // The pausing edge does not advance the prescaler, so a
                        // resumed partial second keeps its exact remaining length.
                        if (pause_press) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (sec_presc == SEC_LAST) begin
                            sec_presc <= '0;
                            {sec_tens, sec_ones} <= inc60({sec_tens, sec_ones});
                            if ({sec_tens, sec_ones} == 8'h59) begin
                                {min_tens, min_ones} <= inc60({min_tens, min_ones});
                            end
                        end else begin
                            sec_presc <= sec_presc + SW'(1);
                        end
                    end
                    ADJUST: begin
                        if (adj_presc == ADJ_LAST) begin
                            adj_presc <= '0;
                            blink     <= ~blink;
                            if (sel_state) begin
                                {min_tens, min_ones} <= inc60({min_tens, min_ones});
                            end else begin
                                {sec_tens, sec_ones} <= inc60({sec_tens, sec_ones});
                            end
                        end else begin
                            adj_presc <= adj_presc + AW'(1);
                        end
                    end
                    default: begin
                        state     <= PAUSED;
                        running   <= 1'b0;
                        adjusting <= 1'b0;
                        blink     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed vector table, async reset sequence, and
// random stimulus checked against a total-seconds reference model.
module tb_stopwatch_ctrl;

    localparam int unsigned SEC = 4;
    localparam int unsigned ADJ = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pause_state = 1'b0;
    logic       reset_state = 1'b0;
    logic       adj_state = 1'b0;
    logic       sel_state = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, adjusting, blink;
    logic [18:0] dv;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0=paused 1=running 2=adjust, time as total seconds.
    int m_mode, m_t, m_sp, m_ap;
    bit m_blink, m_pp, m_rp;

    typedef struct {
        bit p, r, a, s;
        int n;
        int t;
        bit run, adj, blk;
    } vec_t;
    vec_t tbl[$];

    stopwatch_ctrl #(.SEC_DIV(SEC), .ADJ_DIV(ADJ)) dut (
        .clk(clk), .rst_n(rst_n),
        .pause_state(pause_state), .reset_state(reset_state),
        .adj_state(adj_state), .sel_state(sel_state),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .adjusting(adjusting), .blink(blink)
    );

    assign dv = {min_tens, min_ones, sec_tens, sec_ones, running, adjusting, blink};

    always #5 clk = ~clk;

    function automatic logic [18:0] exp_vec(input int t, input bit run, input bit adj, input bit blk);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), run, adj, blk};
    endfunction

    function automatic logic [18:0] model_vec();
        return exp_vec(m_t, m_mode == 1, m_mode == 2, m_blink);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_sp = 0; m_ap = 0;
        m_blink = 0; m_pp = 0; m_rp = 0;
    endtask

    task automatic model_step(input bit p, input bit r, input bit a, input bit s);
        bit pp, rp;
        int mm, ss;
        pp = p && !m_pp;
        rp = r && !m_rp;
        m_pp = p;
        m_rp = r;
        mm = m_t / 60;
        ss = m_t % 60;
        if (rp) begin
            m_t = 0; m_sp = 0; m_ap = 0; m_blink = 0;
            m_mode = a ? 2 : 0;
        end else if (a && m_mode != 2) begin
            m_mode = 2; m_ap = 0; m_blink = 0;
        end else if (!a && m_mode == 2) begin
            m_mode = 0; m_blink = 0;
        end else if (m_mode == 2) begin
            m_ap++;
            if (m_ap == ADJ) begin
                m_ap = 0;
                m_blink = !m_blink;
                if (s) m_t = ((mm + 1) % 60) * 60 + ss;
                else   m_t = mm * 60 + (ss + 1) % 60;
            end
        end else if (pp) begin
            m_mode = (m_mode == 1) ? 0 : 1;
        end else if (m_mode == 1) begin
            m_sp++;
            if (m_sp == SEC) begin
                m_sp = 0;
                m_t = (m_t + 1) % 3600;
            end
        end
    endtask

    task automatic cycle(input bit p, input bit r, input bit a, input bit s);
        pause_state = p;
        reset_state = r;
        adj_state   = a;
        sel_state   = s;
        @(posedge clk);
        model_step(p, r, a, s);
        #1;
    endtask

    task automatic check(input string name, input logic [18:0] exp);
        total++;
        if (dv !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (mm:ss got %h%h:%h%h run/adj/blink %b%b%b)",
                     name, dv, exp, min_tens, min_ones, sec_tens, sec_ones,
                     running, adjusting, blink);
        end
    endtask

    task automatic add(input bit p, input bit r, input bit a, input bit s, input int n,
                       input int t, input bit run, input bit adj, input bit blk);
        vec_t v;
        v.p = p; v.r = r; v.a = a; v.s = s; v.n = n;
        v.t = t; v.run = run; v.adj = adj; v.blk = blk;
        tbl.push_back(v);
    endtask

    initial begin
        bit rp, rr, ra, rs;

        //  p  r  a  s   n     t     run adj blk
        add(1, 0, 0, 0,   1,    0,   1,  0,  0);  // press -> running
        add(0, 0, 0, 0,   4,    1,   1,  0,  0);  // first second
        add(0, 0, 0, 0,  36,   10,   1,  0,  0);  // 00:10
        add(1, 0, 0, 0,  20,   10,   0,  0,  0);  // held button: one toggle
        add(0, 0, 0, 0,   1,   10,   0,  0,  0);
        add(1, 0, 0, 0,   1,   10,   1,  0,  0);
        add(0, 0, 0, 0,   2,   10,   1,  0,  0);  // partial second
        add(1, 0, 0, 0,   1,   10,   0,  0,  0);  // pause mid-second
        add(0, 0, 0, 0,   5,   10,   0,  0,  0);  // frozen
        add(1, 0, 0, 0,   1,   10,   1,  0,  0);
        add(0, 0, 0, 0,   1,   10,   1,  0,  0);
        add(0, 0, 0, 0,   1,   11,   1,  0,  0);  // resumed second
        add(0, 0, 1, 0,   1,   11,   0,  1,  0);  // enter adjust
        add(0, 0, 1, 0, 141,   58,   0,  1,  1);
        add(0, 0, 1, 1, 177, 3598,   0,  1,  0);  // 59:58
        add(0, 0, 0, 0,   1, 3598,   0,  0,  0);
        add(1, 0, 0, 0,   1, 3598,   1,  0,  0);
        add(0, 0, 0, 0,   4, 3599,   1,  0,  0);
        add(0, 0, 0, 0,   4,    0,   1,  0,  0);  // 59:59 -> 00:00
        add(0, 0, 1, 0,   1,    0,   0,  1,  0);
        add(0, 0, 1, 0, 174,   58,   0,  1,  0);
        add(0, 0, 1, 0,   3,   59,   0,  1,  1);
        add(0, 0, 1, 0,   3,    0,   0,  1,  0);  // seconds wrap, no carry
        add(0, 0, 1, 1,   3,   60,   0,  1,  1);
        add(0, 0, 0, 0,   1,   60,   0,  0,  0);
        add(0, 0, 1, 1,   1,   60,   0,  1,  0);
        add(0, 0, 1, 1,   6,  180,   0,  1,  0);
        add(0, 0, 1, 0,  81,  207,   0,  1,  1);  // 03:27
        add(0, 0, 0, 0,   1,  207,   0,  0,  0);
        add(1, 0, 0, 0,   1,  207,   1,  0,  0);
        add(0, 0, 0, 0,   3,  207,   1,  0,  0);  // prescaler at last count
        add(1, 1, 0, 0,   1,    0,   0,  0,  0);  // reset+pause together
        add(0, 0, 0, 0,   4,    0,   0,  0,  0);
        add(0, 1, 1, 0,   1,    0,   0,  1,  0);  // reset press into adjust
        add(0, 1, 1, 0,   3,    1,   0,  1,  1);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", '0);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);
        check("release", exp_vec(0, 0, 0, 0));

        foreach (tbl[i]) begin
            repeat (tbl[i].n) cycle(tbl[i].p, tbl[i].r, tbl[i].a, tbl[i].s);
            check($sformatf("vec%0d", i), exp_vec(tbl[i].t, tbl[i].run, tbl[i].adj, tbl[i].blk));
        end

        // Asynchronous reset between edges while adjusting.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", '0);
        model_reset();
        adj_state = 1'b0;
        @(posedge clk);
        #1;
        check("held_reset", '0);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);
        check("after_release", exp_vec(0, 0, 0, 0));
        cycle(1, 0, 0, 0);
        check("paused_after_release", exp_vec(0, 1, 0, 0));

        rp = 1; rr = 0; ra = 0; rs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) rp = !rp;
            rr = ($urandom_range(59) == 0);
            if ($urandom_range(79) == 0) ra = !ra;
            if ($urandom_range(9) == 0) rs = !rs;
            cycle(rp, rr, ra, rs);
            check($sformatf("rand%0d", i), model_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
